// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and range helper for the UART time-command parser.
// Imported by uart_time_cmd_parser and ascii_digit_decode.
package uart_cmd_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic [3:0] H1_MAX       = 4'd2;
  localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MS1_MAX      = 4'd5;

  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    DIGITS,
    WAIT_TERM,
    DONE,
    ERR
  } state_e;

  typedef enum logic {
    CMD_TIME,
    CMD_ALARM
  } cmd_e;

  typedef struct packed {
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
  } bcd_time_t;

  // Units digits are 0-9 by construction, so only tens digits need limits.
  function automatic logic time_in_range(input logic [3:0] h1, input logic [3:0] h0,
                                         input logic [3:0] m1, input logic [3:0] s1);
    logic hours_ok;
    hours_ok = (h1 < H1_MAX) || ((h1 == H1_MAX) && (h0 <= H0_MAX_AT_20));
    return hours_ok && (m1 <= MS1_MAX) && (s1 <= MS1_MAX);
  endfunction

endpackage

// File: rtl/uart_time_cmd_parser_ascii_digit_decode.sv
// Combinational ASCII decimal-digit decoder: byte -> {is_digit, value}.
module ascii_digit_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] bite,
  output logic       is_digit,
  output logic [3:0] value
);

  always_comb begin
    is_digit = (bite >= CH_0) && (bite <= CH_9);
    // Only meaningful when is_digit is set.
    value    = 4'(bite - CH_0);
  end

endmodule

// File: rtl/uart_time_cmd_parser.sv
// Parses 'T' HHMMSS CR commands from the UART byte stream into BCD time with a set strobe.
// Optional macro ALARM_CMD_EN adds 'A' HHMMSS CR alarm commands and the alarm ports.
module uart_time_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bite,
  input  logic       use_byte,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       set_time,
  output logic       cmd_error,
  output logic       busy
`ifdef ALARM_CMD_EN
  ,
  output logic [7:0] al_hours,
  output logic [7:0] al_minutes,
  output logic [7:0] al_seconds,
  output logic       set_alarm
`endif
);

  state_e          state_q,     state_d;
  logic [2:0]      idx_q,       idx_d;
  logic [5:0][3:0] shadow_q,    shadow_d;
  logic [TW-1:0]   timeout_q,   timeout_d;
  bcd_time_t       time_q,      time_d;
  logic            set_time_q,  set_time_d;
  logic            cmd_error_q, cmd_error_d;
  logic            busy_q,      busy_d;
`ifdef ALARM_CMD_EN
  cmd_e            cmd_q,       cmd_d;
  bcd_time_t       alarm_q,     alarm_d;
  logic            set_alarm_q, set_alarm_d;
`endif

  logic       is_digit;
  logic [3:0] digit_val;
  logic       is_start;
  logic       range_ok;
  bcd_time_t  shadow_time;

  ascii_digit_decode u_digit_decode (
    .bite     (bite),
    .is_digit (is_digit),
    .value    (digit_val)
  );

`ifdef ALARM_CMD_EN
  assign is_start = (bite == CH_T) || (bite == CH_A);
`else
  assign is_start = (bite == CH_T);
`endif

  assign range_ok    = time_in_range(shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[4]);
  assign shadow_time = '{hours:   {shadow_q[0], shadow_q[1]},
                         minutes: {shadow_q[2], shadow_q[3]},
                         seconds: {shadow_q[4], shadow_q[5]}};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    timeout_d   = timeout_q;
    time_d      = time_q;
    set_time_d  = 1'b0;
    cmd_error_d = 1'b0;
`ifdef ALARM_CMD_EN
    cmd_d       = cmd_q;
    alarm_d     = alarm_q;
    set_alarm_d = 1'b0;
`endif

    case (state_q)
      DIGITS, WAIT_TERM: begin
        timeout_d = timeout_q + 1'b1;
        if (use_byte) begin
          timeout_d = '0;
          if (is_start) begin
            state_d = DIGITS;
            idx_d   = '0;
`ifdef ALARM_CMD_EN
            cmd_d   = (bite == CH_A) ? CMD_ALARM : CMD_TIME;
`endif
          end else if ((state_q == DIGITS) && is_digit) begin
            shadow_d[idx_q] = digit_val;
            if (idx_q == LAST_IDX) state_d = WAIT_TERM;
            else                   idx_d   = idx_q + 3'd1;
          end else if ((state_q == WAIT_TERM) && (bite == CH_CR) && range_ok) begin
            // Results are registered on the CR edge so they appear together with the strobe.
            state_d = DONE;
`ifdef ALARM_CMD_EN
            if (cmd_q == CMD_ALARM) begin
              alarm_d     = shadow_time;
              set_alarm_d = 1'b1;
            end else
`endif
            begin
              time_d     = shadow_time;
              set_time_d = 1'b1;
            end
          end else begin
            state_d     = ERR;
            cmd_error_d = 1'b1;
          end
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 2)) begin
          // The count would reach TIMEOUT_CYCLES-1 on this edge with no byte seen.
          state_d     = ERR;
          cmd_error_d = 1'b1;
        end
      end

      default: begin
        // IDLE, and the single-cycle DONE/ERR states, all treat a new byte as IDLE would.
        state_d   = IDLE;
        timeout_d = '0;
        if (use_byte && is_start) begin
          state_d = DIGITS;
          idx_d   = '0;
`ifdef ALARM_CMD_EN
          cmd_d   = (bite == CH_A) ? CMD_ALARM : CMD_TIME;
`endif
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      // NOTE: the shadow digits are reset too, so an aborted command leaves nothing behind.
      shadow_q    <= '0;
      timeout_q   <= '0;
      time_q      <= '0;
      set_time_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALARM_CMD_EN
      cmd_q       <= CMD_TIME;
      alarm_q     <= '0;
      set_alarm_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      timeout_q   <= timeout_d;
      time_q      <= time_d;
      set_time_q  <= set_time_d;
      cmd_error_q <= cmd_error_d;
      busy_q      <= busy_d;
`ifdef ALARM_CMD_EN
      cmd_q       <= cmd_d;
      alarm_q     <= alarm_d;
      set_alarm_q <= set_alarm_d;
`endif
    end
  end

  assign hours     = time_q.hours;
  assign minutes   = time_q.minutes;
  assign seconds   = time_q.seconds;
  assign set_time  = set_time_q;
  assign cmd_error = cmd_error_q;
  assign busy      = busy_q;
`ifdef ALARM_CMD_EN
  assign al_hours   = alarm_q.hours;
  assign al_minutes = alarm_q.minutes;
  assign al_seconds = alarm_q.seconds;
  assign set_alarm  = set_alarm_q;
`endif

endmodule

// File: tb/tb_uart_time_cmd_parser.sv
// Self-checking bench for uart_time_cmd_parser: directed byte streams with a strobe scoreboard.
`timescale 1ns/1ps
module tb_uart_time_cmd_parser;

  localparam int TO = 50;

  typedef enum logic [1:0] {EV_SET, EV_ERR, EV_ALARM} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [23:0] t;
    logic [23:0] al;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bite = 8'h00;
  logic       use_byte = 1'b0;
  logic [7:0] hours, minutes, seconds;
  logic       set_time, cmd_error, busy;
  logic       al_strobe;
  logic [23:0] al_obs;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] cur_t  = '0;
  logic [23:0] cur_al = '0;

`ifdef ALARM_CMD_EN
  logic [7:0] al_hours, al_minutes, al_seconds;
  logic       set_alarm;
  assign al_strobe = set_alarm;
  assign al_obs    = {al_hours, al_minutes, al_seconds};
`else
  assign al_strobe = 1'b0;
  assign al_obs    = '0;
`endif

  uart_time_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bite      (bite),
    .use_byte  (use_byte),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .set_time  (set_time),
    .cmd_error (cmd_error),
    .busy      (busy)
`ifdef ALARM_CMD_EN
    ,
    .al_hours   (al_hours),
    .al_minutes (al_minutes),
    .al_seconds (al_seconds),
    .set_alarm  (set_alarm)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input string d);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[19:0], 4'(d[i] - 8'h30)};
    return r;
  endfunction

  function automatic bit valid_time(input string d);
    int h, m, s;
    h = (d[0] - 48) * 10 + (d[1] - 48);
    m = (d[2] - 48) * 10 + (d[3] - 48);
    s = (d[4] - 48) * 10 + (d[5] - 48);
    return (h < 24) && (m < 60) && (s < 60);
  endfunction

  // Called at a falling edge; the byte is consumed on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    bite     = b;
    use_byte = 1'b1;
    @(negedge clk);
    use_byte = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_cmd(input logic [7:0] start, input string d, input int gap);
    exp_t e;
    send_byte(start);
    idle(gap);
    for (int i = 0; i < d.len(); i++) begin
      send_byte(d[i]);
      idle(gap);
    end
    if (start == 8'h54) begin
      if (valid_time(d)) begin
        cur_t = to_bcd(d);
        e = '{kind: EV_SET, t: cur_t, al: cur_al};
      end else begin
        e = '{kind: EV_ERR, t: cur_t, al: cur_al};
      end
      exp_q.push_back(e);
    end
`ifdef ALARM_CMD_EN
    else if (start == 8'h41) begin
      if (valid_time(d)) begin
        cur_al = to_bcd(d);
        e = '{kind: EV_ALARM, t: cur_t, al: cur_al};
      end else begin
        e = '{kind: EV_ERR, t: cur_t, al: cur_al};
      end
      exp_q.push_back(e);
    end
`endif
    send_byte(8'h0D);
  endtask

  task automatic push_err();
    exp_q.push_back('{kind: EV_ERR, t: cur_t, al: cur_al});
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (set_time || cmd_error || al_strobe)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, set_time, cmd_error, al_strobe}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {29'd0, set_time, cmd_error, al_strobe},
              (mon_e.kind == EV_SET) ? 32'd4 : (mon_e.kind == EV_ERR) ? 32'd2 : 32'd1);
        check("time_value", {8'd0, hours, minutes, seconds}, {8'd0, mon_e.t});
        check("alarm_value", {8'd0, al_obs}, {8'd0, mon_e.al});
      end
    end
  end

  initial begin
    int first;

    // Reset state
    idle(3);
    check("rst_hours", hours, 0);
    check("rst_minutes", minutes, 0);
    check("rst_seconds", seconds, 0);
    check("rst_set_time", set_time, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // Basic command, 20-cycle spacing, exact latency and pulse width
    send_byte("T");
    check("busy_after_start", busy, 1);
    idle(20);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h31 + 8'(i));
      idle(20);
    end
    cur_t = 24'h123456;
    exp_q.push_back('{kind: EV_SET, t: cur_t, al: cur_al});
    send_byte(8'h0D);
    check("set_time_latency", set_time, 1);
    check("hours_12", hours, 8'h12);
    @(negedge clk);
    check("set_time_width", set_time, 0);
    check("busy_idle_after_done", busy, 0);
    idle(3);

    // Range limits
    run_cmd("T", "240000", 2);
    idle(3);
    check("hours_held_240000", hours, 8'h12);
    run_cmd("T", "236000", 2);
    idle(3);
    run_cmd("T", "235959", 2);
    idle(3);
    check("hours_23", hours, 8'h23);

    // Non-digit inside a command
    push_err();
    send_byte("T");
    send_byte("1");
    send_byte("X");
    check("err_after_x", cmd_error, 1);
    idle(3);
    run_cmd("T", "000001", 1);
    idle(3);
    check("seconds_01", seconds, 8'h01);

    // Restart mid-command
    send_byte("T");
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
    run_cmd("T", "010203", 0);
    idle(3);

    // Timeout: exactly TO-1 edges of silence after the last byte
    push_err();
    send_byte("T");
    idle(3);
    send_byte("1");
    first = -1;
    for (int k = 1; k <= 60 && first < 0; k++) begin
      @(negedge clk);
      if (cmd_error) first = k;
    end
    check("timeout_latency", first, TO - 1);
    @(negedge clk);
    check("busy_after_timeout", busy, 0);
    idle(3);

    // Byte landing on the expiry cycle wins
    send_byte("T");
    idle(3);
    send_byte("1");
    idle(TO - 2);
    send_byte("2");
    check("no_err_on_expiry_byte", cmd_error, 0);
    check("busy_on_expiry_byte", busy, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h33 + 8'(i));
    cur_t = 24'h123456;
    exp_q.push_back('{kind: EV_SET, t: cur_t, al: cur_al});
    send_byte(8'h0D);
    idle(3);

    // Reset mid-command
    send_byte("T");
    send_byte("0");
    send_byte("9");
    send_byte("1");
    send_byte("5");
    reset = 1'b1;
    idle(2);
    check("midrst_time", {hours, minutes, seconds}, 0);
    check("midrst_strobes", {set_time, cmd_error, al_strobe}, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    cur_t  = '0;
    cur_al = '0;
    idle(2);
    run_cmd("T", "083000", 1);
    idle(3);
    check("hours_after_rst", hours, 8'h08);

`ifdef ALARM_CMD_EN
    run_cmd("A", "070000", 1);
    idle(3);
    check("alarm_hours", al_obs[23:16], 8'h07);
    check("alarm_keeps_hours", hours, 8'h08);
`else
    run_cmd("A", "070000", 1);
    idle(3);
    check("a_ignored_busy", busy, 0);
    check("a_ignored_hours", hours, 8'h08);
    push_err();
    send_byte("T");
    send_byte("1");
    send_byte("A");
    check("a_in_cmd_err", cmd_error, 1);
    idle(3);
`endif

    idle(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
